// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, keeps one imem request in flight, and absorbs decode stalls in a one-entry hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] pcf;
    logic [31:0] req_addr;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    logic [31:0] req_next;
    logic [31:0] hold_next;
    logic [31:0] target;
    logic        rsp;
    logic        unused_low;

    assign imem_req   = (state == FETCH) || (state == DROP);
    assign imem_addr  = req_addr;
    assign rsp        = imem_req && imem_valid;
    assign req_next   = req_addr + 32'd4;
    assign hold_next  = hold_pc + 32'd4;
    assign target     = {redirect_pc[31:2], 2'b00};
    assign unused_low = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pcf        <= RESET_PC;
            req_addr   <= RESET_PC;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
            InstrD     <= NOP_INSTR;
            PCD        <= 32'h0;
            PCPlus4D   <= 32'h0;
            ValidD     <= 1'b0;
        end else if (redirect) begin
            // Redirect wins over stall and flush; D is always bubbled.
            pcf        <= target;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
            InstrD     <= NOP_INSTR;
            ValidD     <= 1'b0;
            case (state)
                FETCH, DROP: begin
                    if (rsp) begin
                        req_addr <= target;
                        state    <= FETCH;
                    end else begin
                        // The in-flight request must still complete before the new address goes out.
                        state <= DROP;
                    end
                end
                default: begin
                    req_addr <= target;
                    state    <= FETCH;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    req_addr <= pcf;
                    state    <= FETCH;
                    if (flush_d || !stall_d) begin
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                    end
                end
                FETCH: begin
                    if (flush_d) begin
                        // Response (if any) is thrown away; the same address is fetched again.
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                    end else if (rsp) begin
                        if (stall_d) begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= req_addr;
                            state      <= HOLD;
                        end else begin
                            InstrD   <= imem_rdata;
                            PCD      <= req_addr;
                            PCPlus4D <= req_next;
                            ValidD   <= 1'b1;
                            pcf      <= req_next;
                            req_addr <= req_next;
                        end
                    end else if (!stall_d) begin
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush_d) begin
                        InstrD     <= NOP_INSTR;
                        ValidD     <= 1'b0;
                        pcf        <= hold_pc;
                        req_addr   <= hold_pc;
                        hold_instr <= 32'h0;
                        hold_pc    <= 32'h0;
                        state      <= FETCH;
                    end else if (!stall_d) begin
                        InstrD   <= hold_instr;
                        PCD      <= hold_pc;
                        PCPlus4D <= hold_next;
                        ValidD   <= 1'b1;
                        pcf      <= hold_next;
                        req_addr <= hold_next;
                        state    <= FETCH;
                    end
                end
                DROP: begin
                    if (flush_d || !stall_d) begin
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                    end
                    // pcf already holds the redirect target.
                    if (rsp) begin
                        req_addr <= pcf;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
